alu_mdu_unit: RTL and testbench
===============================

Name: alu_mdu_unit

Overview:
- Parametrised successor to the combinational ALU-control decoder.
- Merges ALUOp/funct3/funct7 decode with a registered execute stage for RV32I/RV64I R-type ops and an iterative RV-M multiply/divide datapath.
- Sits between register-read and writeback in the multi-cycle core.
- Uses a valid/ready handshake on both sides, so the core stalls while MUL/DIV iterate.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of any in-flight op.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request this cycle.
- alu_op  in  2  00 load/store add, 01 branch sub, 10 R-type decode, 11 reserved (illegal).
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- op_a  in  XLEN  rs1 operand.
- op_b  in  XLEN  rs2 operand.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  operation result.
- zero  out  1  result == 0 (branch compare).
- illegal  out  1  undecodable op; qualified by out_valid.

Behaviour:
- Reset values: in_ready=0 while rst asserted, 1 in the first cycle after deassertion. out_valid=0, result=0, zero=0, illegal=0. FSM goes to IDLE and the counter clears.
- Accept condition: in_valid && in_ready. in_ready=1 only in IDLE.
- Decode for alu_op=10:
  - funct7=0000000: add, sll, slt, sltu, xor, srl, or, and on funct3 000..111.
  - funct7=0100000: sub (funct3=000), sra (funct3=101).
  - funct7=0000001: mul, mulh, mulhsu, mulhu, div, divu, rem, remu on funct3 000..111.
  - Any other combination is illegal: result=0, illegal=1.
- Shift amount = op_b[$clog2(XLEN)-1:0].
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, on accept:
  - ALU op: result registered, go to DONE. out_valid rises the cycle after accept (latency 1).
  - Multiply: latch operand magnitudes and a sign-fix flag, counter=XLEN, go to MUL.
  - Divide/remainder: same latching, go to DIV. Two special cases bypass DIV and go straight to DONE with latency 1:
    - Divide by zero (op_b==0): quotient = all ones, rem = op_a.
    - Signed overflow (op_a = MIN, op_b = -1): quotient = MIN, rem = 0.
- MUL: one shift-add step per cycle on a 2*XLEN product. When the counter reaches 0, apply two's-complement fix-up and select the low half (mul) or high half (mulh*), then go to DONE. Latency XLEN+1 cycles from accept to out_valid.
- DIV: one restoring-division step per cycle. Sign fix-up: the quotient takes the sign of a^b; the remainder takes the sign of the dividend. Latency XLEN+1.
- DONE:
  - out_valid=1. result, zero and illegal are held stable until out_ready.
  - On out_valid && out_ready, go to IDLE next cycle. in_ready is not combinationally forwarded, so there are no back-to-back accepts: minimum 2 cycles per ALU op.
- flush: from any state, go to IDLE next cycle with out_valid=0 and the counter cleared. flush outranks a simultaneous accept or drain: the request is dropped.
- rst asserted mid-MUL/DIV: immediate abort to reset values. No partial result is ever presented.
- Width rules:
  - slt/sltu produce a 0/1 zero-extended result.
  - sra sign-fills.
  - All arithmetic wraps modulo 2^XLEN.
- zero = ~|result, registered with result.

Decomposition:
- Package alu_mdu_pkg holds:
  - the ALUOp enum (LDST, BR, RTYPE, RSVD);
  - the funct7 constants F7_BASE, F7_ALT, F7_MULDIV;
  - the funct3 op codes;
  - the FSM state typedef;
  - the internal op-class enum (ALU, MUL, DIV, ILL).
- One sub-module, alu_mdu_decode: combinational decode of {alu_op, funct3, funct7} to {op class, ALU select, signedness flags, high-half/remainder select}.
- The top module holds the FSM, the single-cycle ALU and the iterative datapath.

Test Plan:
- alu_op=10, funct3=000, funct7=0100000, a=5, b=7 -> result=FFFFFFFE, zero=0, out_valid exactly 1 cycle after accept.
- alu_op=01, a=b=0x1234 -> result=0, zero=1. Then alu_op=10 with funct7=0000011 -> illegal=1, result=0.
- mulh a=0x80000000, b=0x80000000 -> result=0x40000000 at cycle 33 after accept. Hold out_ready=0 for 5 cycles -> result stable and in_ready=0 throughout.
- Special divides:
  - div a=0x80000000, b=0xFFFFFFFF -> result=0x80000000, latency 1.
  - divu by 0 -> FFFFFFFF.
  - rem a=-7, b=0 -> FFFFFFF9.
- rem a=-7, b=2 -> FFFFFFFF. divu a=100, b=7 -> 14, latency 33.
- flush at cycle 10 of a div -> out_valid never rises, in_ready=1 next cycle, and a following add 2+3 returns 5. Async rst pulse mid-mul -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: shared encodings for the ALU / multiply-divide execute unit.
package alu_mdu_pkg;

  typedef enum logic [1:0] {
    LDST  = 2'b00,
    BR    = 2'b01,
    RTYPE = 2'b10,
    RSVD  = 2'b11
  } alu_op_e;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_SUB    = 3'b000;
  localparam logic [2:0] F3_SRA    = 3'b101;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Low 3 bits mirror funct3; bit 3 marks the funct7=0100000 variants.
  typedef enum logic [3:0] {
    A_ADD  = 4'd0,
    A_SLL  = 4'd1,
    A_SLT  = 4'd2,
    A_SLTU = 4'd3,
    A_XOR  = 4'd4,
    A_SRL  = 4'd5,
    A_OR   = 4'd6,
    A_AND  = 4'd7,
    A_SUB  = 4'd8,
    A_SRA  = 4'd13
  } alu_sel_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    C_ALU,
    C_MUL,
    C_DIV,
    C_ILL
  } op_class_e;

endpackage

// File: rtl/alu_mdu_decode.sv
// alu_mdu_decode: maps {alu_op, funct3, funct7} to op class, ALU select and
// multiply/divide signedness and high-half/remainder selection.
module alu_mdu_decode
  import alu_mdu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output op_class_e  op_class,
  output alu_sel_e   alu_sel,
  output logic       a_signed,
  output logic       b_signed,
  output logic       hi_sel
);

  always_comb begin
    op_class = C_ILL;
    alu_sel  = A_ADD;
    a_signed = 1'b0;
    b_signed = 1'b0;
    hi_sel   = 1'b0;
    case (alu_op_e'(alu_op))
      LDST: op_class = C_ALU;
      BR: begin
        op_class = C_ALU;
        alu_sel  = A_SUB;
      end
      RTYPE: begin
        if (funct7 == F7_BASE) begin
          op_class = C_ALU;
          alu_sel  = alu_sel_e'({1'b0, funct3});
        end else if (funct7 == F7_ALT && (funct3 == F3_SUB || funct3 == F3_SRA)) begin
          op_class = C_ALU;
          alu_sel  = alu_sel_e'({1'b1, funct3});
        end else if (funct7 == F7_MULDIV) begin
          op_class = funct3[2] ? C_DIV : C_MUL;
          case (funct3)
            F3_MUL:    {a_signed, b_signed, hi_sel} = 3'b000;
            F3_MULH:   {a_signed, b_signed, hi_sel} = 3'b111;
            F3_MULHSU: {a_signed, b_signed, hi_sel} = 3'b101;
            F3_MULHU:  {a_signed, b_signed, hi_sel} = 3'b001;
            F3_DIV:    {a_signed, b_signed, hi_sel} = 3'b110;
            F3_DIVU:   {a_signed, b_signed, hi_sel} = 3'b000;
            F3_REM:    {a_signed, b_signed, hi_sel} = 3'b111;
            F3_REMU:   {a_signed, b_signed, hi_sel} = 3'b001;
            default:   {a_signed, b_signed, hi_sel} = 3'b000;
          endcase
        end
      end
      default: op_class = C_ILL;
    endcase
  end

endmodule

// File: rtl/alu_mdu_unit.sv
// alu_mdu_unit: registered RV32I/RV64I R-type ALU plus iterative shift-add
// multiplier and restoring divider behind valid/ready handshakes.
module alu_mdu_unit
  import alu_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int SH_W  = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]     r_result;
  logic                r_zero;
  logic                r_illegal;
  logic [2*XLEN-1:0]   r_p;
  logic [XLEN-1:0]     r_m;
  logic                r_neg;
  logic                r_rneg;
  logic                r_hi;

  op_class_e           w_class;
  alu_sel_e            w_sel;
  logic                w_as;
  logic                w_bs;
  logic                w_hi;
  logic [SH_W-1:0]     w_shamt;
  logic [XLEN-1:0]     w_alu;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic                w_div0;
  logic                w_ovf;
  logic [XLEN-1:0]     w_dspec;
  logic                w_fast;
  logic [XLEN-1:0]     w_imm;
  logic [XLEN:0]       w_msum;
  logic [2*XLEN-1:0]   w_mnext;
  logic [XLEN:0]       w_trial;
  logic [2*XLEN-1:0]   w_dnext;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_q;
  logic [XLEN-1:0]     w_r;
  logic [XLEN-1:0]     w_fin;

  alu_mdu_decode u_dec (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7   (funct7),
    .op_class (w_class),
    .alu_sel  (w_sel),
    .a_signed (w_as),
    .b_signed (w_bs),
    .hi_sel   (w_hi)
  );

  assign w_shamt = op_b[SH_W-1:0];

  always_comb begin
    w_alu = '0;
    case (w_sel)
      A_ADD:   w_alu = op_a + op_b;
      A_SUB:   w_alu = op_a - op_b;
      A_SLL:   w_alu = op_a << w_shamt;
      A_SLT:   w_alu = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      A_SLTU:  w_alu = {{(XLEN-1){1'b0}}, op_a < op_b};
      A_XOR:   w_alu = op_a ^ op_b;
      A_SRL:   w_alu = op_a >> w_shamt;
      A_SRA:   w_alu = $signed(op_a) >>> w_shamt;
      A_OR:    w_alu = op_a | op_b;
      A_AND:   w_alu = op_a & op_b;
      default: w_alu = '0;
    endcase
  end

  assign w_a_neg = w_as & op_a[XLEN-1];
  assign w_b_neg = w_bs & op_b[XLEN-1];
  assign w_a_mag = w_a_neg ? -op_a : op_a;
  assign w_b_mag = w_b_neg ? -op_b : op_b;
  assign w_div0  = op_b == '0;
  assign w_ovf   = w_as && op_a == MIN && op_b == '1;
  assign w_dspec = w_div0 ? (w_hi ? op_a : '1) : (w_hi ? '0 : MIN);
  assign w_fast  = w_class == C_ALU || w_class == C_ILL || (w_class == C_DIV && (w_div0 || w_ovf));
  assign w_imm   = w_class == C_ALU ? w_alu : w_class == C_DIV ? w_dspec : '0;

  // r_p = {partial product high, multiplier} during MUL, {remainder, quotient} during DIV.
  assign w_msum  = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_m} : '0);
  assign w_mnext = {w_msum, r_p[XLEN-1:1]};
  assign w_trial = r_p[2*XLEN-1:XLEN-1] - {1'b0, r_m};
  assign w_dnext = w_trial[XLEN] ? {r_p[2*XLEN-2:0], 1'b0}
                                 : {w_trial[XLEN-1:0], r_p[XLEN-2:0], 1'b1};
  assign w_prod  = r_neg ? -w_mnext : w_mnext;
  assign w_q     = w_dnext[XLEN-1:0];
  assign w_r     = w_dnext[2*XLEN-1:XLEN];
  assign w_fin   = r_state == S_MUL ? (r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0])
                 : r_hi ? (r_rneg ? -w_r : w_r) : (r_neg ? -w_q : w_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
      r_p       <= '0;
      r_m       <= '0;
      r_neg     <= 1'b0;
      r_rneg    <= 1'b0;
      r_hi      <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          if (w_fast) begin
            r_result  <= w_imm;
            r_zero    <= ~|w_imm;
            r_illegal <= w_class == C_ILL;
            r_state   <= S_DONE;
          end else begin
            r_p     <= {{XLEN{1'b0}}, w_class == C_MUL ? w_b_mag : w_a_mag};
            r_m     <= w_class == C_MUL ? w_a_mag : w_b_mag;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_rneg  <= w_a_neg;
            r_hi    <= w_hi;
            r_cnt   <= CNT_W'(XLEN);
            r_state <= w_class == C_MUL ? S_MUL : S_DIV;
          end
        end
        S_MUL, S_DIV: begin
          r_p   <= r_state == S_MUL ? w_mnext : w_dnext;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_result  <= w_fin;
            r_zero    <= ~|w_fin;
            r_illegal <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_state == S_IDLE && !rst;
  assign out_valid = r_state == S_DONE;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_mdu_unit.sv
// tb_alu_mdu_unit: directed self-checking bench for alu_mdu_unit (XLEN=32).
module tb_alu_mdu_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = 2'b00;
  logic [2:0]  funct3 = 3'b000;
  logic [6:0]  funct7 = 7'b0000000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  int lat;

  alu_mdu_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7    (funct7),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if ({result, zero, illegal} !== 34'h0) begin errors++; $display("FAIL reset_outputs got %h/%b/%b exp 0", result, zero, illegal); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_sub();
    issue(2'b10, 3'b000, 7'b0100000, 32'd5, 32'd7);
    wait_valid(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sub_latency got %0d exp 1", lat); end
    checks++; if (result !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_result got %h exp FFFFFFFE", result); end
    checks++; if (zero !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL sub_flags got z=%b i=%b exp 0/0", zero, illegal); end
    drain();
  endtask

  task automatic test_branch_illegal();
    issue(2'b01, 3'b000, 7'b0000000, 32'h1234, 32'h1234);
    wait_valid(lat);
    checks++; if (result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL branch_eq got %h z=%b exp 0 z=1", result, zero); end
    drain();
    issue(2'b10, 3'b000, 7'b0000011, 32'h55, 32'h66);
    wait_valid(lat);
    checks++; if (illegal !== 1'b1 || result !== 32'h0) begin errors++; $display("FAIL illegal_f7 got i=%b r=%h exp i=1 r=0", illegal, result); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency got %0d exp 1", lat); end
    drain();
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        ill;
    int          lt;
  } vec_t;

  task automatic test_ops_table();
    vec_t v[$];
    v.push_back('{2'b10, 3'd1, 7'h00, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0, 1});
    v.push_back('{2'b10, 3'd5, 7'h20, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1});
    v.push_back('{2'b10, 3'd5, 7'h00, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1});
    v.push_back('{2'b10, 3'd2, 7'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1});
    v.push_back('{2'b10, 3'd3, 7'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1});
    v.push_back('{2'b10, 3'd4, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1});
    v.push_back('{2'b10, 3'd6, 7'h00, 32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0, 1'b0, 1});
    v.push_back('{2'b10, 3'd7, 7'h00, 32'hF0F0F0F0, 32'h0F0FF000, 32'h0000F000, 1'b0, 1});
    v.push_back('{2'b00, 3'd7, 7'h7F, 32'hFFFFFFFF, 32'h00000003, 32'h00000002, 1'b0, 1});
    v.push_back('{2'b10, 3'd1, 7'h20, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1});
    v.push_back('{2'b11, 3'd0, 7'h00, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1});
    v.push_back('{2'b10, 3'd0, 7'h01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 1'b0, 33});
    v.push_back('{2'b10, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33});
    v.push_back('{2'b10, 3'd2, 7'h01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 33});
    v.push_back('{2'b10, 3'd4, 7'h01, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 33});
    foreach (v[i]) begin
      issue(v[i].op, v[i].f3, v[i].f7, v[i].a, v[i].b);
      wait_valid(lat);
      checks++;
      if (result !== v[i].r || illegal !== v[i].ill || zero !== (v[i].r == 0) || lat !== v[i].lt) begin
        errors++;
        $display("FAIL table_%0d got r=%h i=%b z=%b lat=%0d exp r=%h i=%b lat=%0d",
                 i, result, illegal, zero, lat, v[i].r, v[i].ill, v[i].lt);
      end
      drain();
    end
  endtask

  task automatic test_mulh_hold();
    issue(2'b10, 3'b001, 7'b0000001, 32'h80000000, 32'h80000000);
    wait_valid(lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mulh_latency got %0d exp 33", lat); end
    checks++; if (result !== 32'h40000000) begin errors++; $display("FAIL mulh_result got %h exp 40000000", result); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (result !== 32'h40000000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL mulh_hold_%0d got r=%h ov=%b ir=%b exp 40000000/1/0", c, result, out_valid, in_ready);
      end
    end
    drain();
  endtask

  task automatic test_special_div();
    issue(2'b10, 3'b100, 7'b0000001, 32'h80000000, 32'hFFFFFFFF);
    wait_valid(lat);
    checks++; if (result !== 32'h80000000 || lat !== 1) begin errors++; $display("FAIL div_ovf got %h lat=%0d exp 80000000 lat=1", result, lat); end
    drain();
    issue(2'b10, 3'b101, 7'b0000001, 32'd5, 32'd0);
    wait_valid(lat);
    checks++; if (result !== 32'hFFFFFFFF || lat !== 1) begin errors++; $display("FAIL divu_by0 got %h lat=%0d exp FFFFFFFF lat=1", result, lat); end
    drain();
    issue(2'b10, 3'b110, 7'b0000001, 32'hFFFFFFF9, 32'd0);
    wait_valid(lat);
    checks++; if (result !== 32'hFFFFFFF9 || lat !== 1) begin errors++; $display("FAIL rem_by0 got %h lat=%0d exp FFFFFFF9 lat=1", result, lat); end
    drain();
  endtask

  task automatic test_div();
    issue(2'b10, 3'b110, 7'b0000001, 32'hFFFFFFF9, 32'd2);
    wait_valid(lat);
    checks++; if (result !== 32'hFFFFFFFF || lat !== 33) begin errors++; $display("FAIL rem_neg got %h lat=%0d exp FFFFFFFF lat=33", result, lat); end
    drain();
    issue(2'b10, 3'b101, 7'b0000001, 32'd100, 32'd7);
    wait_valid(lat);
    checks++; if (result !== 32'd14 || lat !== 33) begin errors++; $display("FAIL divu_100_7 got %h lat=%0d exp 0000000E lat=33", result, lat); end
    drain();
  endtask

  task automatic test_flush();
    logic seen;
    seen = 1'b0;
    issue(2'b10, 3'b101, 7'b0000001, 32'd100, 32'd7);
    repeat (9) begin
      @(negedge clk);
      seen |= out_valid;
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
    repeat (40) begin
      @(negedge clk);
      seen |= out_valid;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid got %b exp 0", seen); end
    issue(2'b10, 3'b000, 7'b0000000, 32'd2, 32'd3);
    wait_valid(lat);
    checks++; if (result !== 32'd5 || lat !== 1) begin errors++; $display("FAIL flush_then_add got %h lat=%0d exp 5 lat=1", result, lat); end
    drain();
  endtask

  task automatic test_rst_mid_mul();
    issue(2'b10, 3'b000, 7'b0000001, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got ir=%b ov=%b r=%h z=%b i=%b exp all 0", in_ready, out_valid, result, zero, illegal);
    end
    @(negedge clk);
    rst = 1'b0;
    issue(2'b10, 3'b000, 7'b0000001, 32'd3, 32'd4);
    wait_valid(lat);
    checks++; if (result !== 32'd12 || lat !== 33) begin errors++; $display("FAIL mul_after_rst got %h lat=%0d exp 0000000C lat=33", result, lat); end
    drain();
  endtask

  initial begin
    test_reset();
    test_sub();
    test_branch_illegal();
    test_ops_table();
    test_mulh_hold();
    test_special_div();
    test_div();
    test_flush();
    test_rst_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
